// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        VERT = 2'd1,
        HORZ = 2'd2,
        MAG  = 2'd3
    } conv_mode_t;

    localparam int CONV_LATENCY = 3;

    // Indexed [row][col]; row 0 is the oldest line (y-2), col 0 the oldest column (x-2).
    localparam int GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage: asynchronous read, synchronous write, so a read
// and a write to the same address in one cycle returns the old contents.
module line_buffer_ram #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 streaming Sobel/pass-through engine: position counters, two line buffers,
// window register and a three-stage datapath with one output per accepted input.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 1280,
    parameter int IMG_H  = 1024
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oSOF,
    output logic              oEOF
);

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int SUM_W = DATA_W + 4;
    localparam logic [SUM_W:0] SAT_MAX = (SUM_W + 1)'((2 ** DATA_W) - 1);

    logic [XW-1:0]     r_x, w_x;
    logic [YW-1:0]     r_y, w_y;
    logic              w_sof;
    conv_mode_t        r_mode, w_mode;
    logic [DATA_W-1:0] r_thr, w_thr;
    logic [DATA_W-1:0] w_row_m1, w_row_m2;

    assign w_sof = iSOF & iDVAL;

    // SOF takes effect on the very pixel that carries it.
    always_comb begin
        w_x    = w_sof ? '0 : r_x;
        w_y    = w_sof ? '0 : r_y;
        w_mode = w_sof ? conv_mode_t'(iMODE) : r_mode;
        w_thr  = w_sof ? iTHRESH : r_thr;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_x    <= '0;
            r_y    <= '0;
            r_mode <= VERT;
            r_thr  <= '0;
        end else if (iDVAL) begin
            r_mode <= w_mode;
            r_thr  <= w_thr;
            if (w_x == XW'(IMG_W - 1)) begin
                r_x <= '0;
                r_y <= (w_y == YW'(IMG_H - 1)) ? '0 : w_y + 1'b1;
            end else begin
                r_x <= w_x + 1'b1;
                r_y <= w_y;
            end
        end
    end

    line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_m1 (
        .i_clk   (iCLK),
        .i_we    (iDVAL),
        .i_addr  (w_x),
        .i_wdata (iDATA),
        .o_rdata (w_row_m1)
    );

    line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_m2 (
        .i_clk   (iCLK),
        .i_we    (iDVAL),
        .i_addr  (w_x),
        .i_wdata (w_row_m1),
        .o_rdata (w_row_m2)
    );

    // Stage 1: window shift and per-pixel flags.
    logic [DATA_W-1:0] r_win [3][3];
    logic              r_v1, r_mask1, r_sof1, r_eof1;
    conv_mode_t        r_mode1;
    logic [DATA_W-1:0] r_thr1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= iDVAL;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_row_m2;
            r_win[1][2] <= w_row_m1;
            r_win[2][2] <= iDATA;
            r_mask1     <= (w_x < XW'(2)) || (w_y < YW'(2));
            r_sof1      <= w_sof;
            r_eof1      <= (w_x == XW'(IMG_W - 1)) && (w_y == YW'(IMG_H - 1));
            r_mode1     <= w_mode;
            r_thr1      <= w_thr;
        end
    end

    // Stage 2: signed kernel sums.
    logic signed [SUM_W-1:0] w_gx, w_gy, r_gx2, r_gy2;
    logic [DATA_W-1:0]       r_ctr2, r_thr2;
    logic                    r_v2, r_mask2, r_sof2, r_eof2;
    conv_mode_t              r_mode2;

    always_comb begin
        w_gx = '0;
        w_gy = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_gx = w_gx + SUM_W'(GX[r][c]) * $signed({4'b0, r_win[r][c]});
                w_gy = w_gy + SUM_W'(GY[r][c]) * $signed({4'b0, r_win[r][c]});
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (r_v1) begin
            r_gx2   <= w_gx;
            r_gy2   <= w_gy;
            r_ctr2  <= r_win[1][1];
            r_mask2 <= r_mask1;
            r_sof2  <= r_sof1;
            r_eof2  <= r_eof1;
            r_mode2 <= r_mode1;
            r_thr2  <= r_thr1;
        end
    end

    // Stage 3: magnitude, saturation, masking, threshold.
    logic [SUM_W-1:0]  w_ax, w_ay;
    logic [SUM_W:0]    w_mag;
    logic [DATA_W-1:0] w_sat, w_val, w_out;

    always_comb begin
        w_ax = r_gx2[SUM_W-1] ? -r_gx2 : r_gx2;
        w_ay = r_gy2[SUM_W-1] ? -r_gy2 : r_gy2;
        case (r_mode2)
            VERT:    w_mag = {1'b0, w_ay};
            HORZ:    w_mag = {1'b0, w_ax};
            default: w_mag = {1'b0, w_ax} + {1'b0, w_ay};
        endcase
        w_sat = (w_mag > SAT_MAX) ? '1 : w_mag[DATA_W-1:0];
        w_val = r_mask2 ? '0 : ((r_mode2 == PASS) ? r_ctr2 : w_sat);
        w_out = w_val;
        if (r_thr2 != '0) begin
            w_out = (w_val >= r_thr2) ? '1 : '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
            oSOF  <= 1'b0;
            oEOF  <= 1'b0;
        end else begin
            oDVAL <= r_v2;
            oSOF  <= r_v2 & r_sof2;
            oEOF  <= r_v2 & r_eof2;
            if (r_v2) begin
                oDATA <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine on an 8x6 image with 12-bit pixels.
module tb_conv3x3_engine;

    localparam int DW = 12;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          iCLK = 1'b0;
    logic          iRST, iDVAL, iSOF;
    logic [DW-1:0] iDATA, iTHRESH, oDATA;
    logic [1:0]    iMODE;
    logic          oDVAL, oSOF, oEOF;

    conv3x3_engine #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iSOF    (iSOF),
        .iMODE   (iMODE),
        .iTHRESH (iTHRESH),
        .oDATA   (oDATA),
        .oDVAL   (oDVAL),
        .oSOF    (oSOF),
        .oEOF    (oEOF)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int data;
        bit sof;
        bit eof;
        int due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   img [H][W];
    int   exp_mode = 1;
    int   exp_thr  = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fill(input int split, input int a, input int b);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (y < split) ? a : b;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference result for input pixel (x,y): window is rows y-2..y, cols x-2..x.
    function automatic int model(input int x, input int y, input int m, input int t);
        int gx, gy, v;
        if (x < 2 || y < 2) begin
            v = 0;
        end else begin
            gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x])
               - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
            gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x])
               - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
            case (m)
                0:       v = img[y-1][x-1];
                1:       v = iabs(gy);
                2:       v = iabs(gx);
                default: v = iabs(gx) + iabs(gy);
            endcase
            if (v > 4095) v = 4095;
        end
        if (t != 0) v = (v >= t) ? 4095 : 0;
        return v;
    endfunction

    task automatic send_frame(input int mode, input int thr, input bit sof, input int gap,
                              input int reset_at, input int chg_at, input int chg_mode);
        int x, y;
        for (int idx = 0; idx < W*H; idx++) begin
            x = idx % W;
            y = idx / W;
            if (idx == reset_at) begin
                @(posedge iCLK); #1;
                iDVAL = 1'b0;
                iSOF  = 1'b0;
                iRST  = 1'b1;
                @(posedge iCLK); #1;
                sb.delete();
                chk("midrst_dval", int'(oDVAL), 0);
                chk("midrst_data", int'(oDATA), 0);
                iRST     = 1'b0;
                exp_mode = 1;
                exp_thr  = 0;
                return;
            end
            while (gap > 0 && int'($urandom_range(99, 0)) < gap) begin
                @(posedge iCLK); #1;
                iDVAL = 1'b0;
                iSOF  = 1'b0;
            end
            @(posedge iCLK); #1;
            iMODE   = (chg_at >= 0 && idx >= chg_at) ? 2'(chg_mode) : 2'(mode);
            iTHRESH = DW'(thr);
            iSOF    = sof && idx == 0;
            iDVAL   = 1'b1;
            iDATA   = DW'(img[y][x]);
            if (sof && idx == 0) begin
                exp_mode = mode;
                exp_thr  = thr;
            end
            sb.push_back('{model(x, y, exp_mode, exp_thr), sof && idx == 0,
                           idx == W*H-1, cyc + 3});
        end
        @(posedge iCLK); #1;
        iDVAL = 1'b0;
        iSOF  = 1'b0;
    endtask

    // Monitor: every presented output is matched against the oldest expectation.
    always @(negedge iCLK) begin
        exp_t e;
        if (oDVAL) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data %0d with empty scoreboard (cycle %0d)",
                         oDATA, cyc);
            end else begin
                e = sb.pop_front();
                chk("data", int'(oDATA), e.data);
                chk("sof", int'(oSOF), int'(e.sof));
                chk("eof", int'(oEOF), int'(e.eof));
                chk("latency", cyc, e.due);
            end
        end else if (oSOF || oEOF) begin
            total++;
            bad++;
            $display("FAIL stray_marker: got sof=%0d eof=%0d with oDVAL=0, expected none",
                     oSOF, oEOF);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0;
        iDATA = '0; iMODE = 2'd0; iTHRESH = '0;
        repeat (2) begin
            @(posedge iCLK); #1;
            chk("rst_dval", int'(oDVAL), 0);
            chk("rst_data", int'(oDATA), 0);
            chk("rst_sof", int'(oSOF), 0);
            chk("rst_eof", int'(oEOF), 0);
        end
        iRST = 1'b0;

        fill(H, 777, 777);   send_frame(0, 0, 1'b1, 0, -1, -1, 0);
        fill(3, 100, 400);   send_frame(1, 0, 1'b1, 0, -1, -1, 0);
        send_frame(2, 0, 1'b1, 0, -1, -1, 0);
        fill(2, 0, 4095);    send_frame(3, 0, 1'b1, 0, -1, -1, 0);
        fill(H, 50, 50);     send_frame(0, 40, 1'b1, 0, -1, -1, 0);
        send_frame(0, 60, 1'b1, 0, -1, -1, 0);
        fill(3, 100, 400);   send_frame(1, 0, 1'b1, 50, -1, -1, 0);
        send_frame(1, 0, 1'b1, 0, -1, 24, 2);
        send_frame(2, 0, 1'b1, 0, -1, -1, 0);
        fill(H, 777, 777);   send_frame(0, 0, 1'b1, 0, 20, -1, 0);
        // Frame after reset without SOF: reset-default mode (|Gy|) must apply.
        fill(3, 100, 400);   send_frame(0, 0, 1'b0, 0, -1, -1, 0);
        send_frame(3, 0, 1'b1, 30, -1, -1, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge iCLK);
        #1;
        chk("drain_pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
